// File: rtl/ad1939_cfg_arbiter.sv
`timescale 1ns/1ps
// AD1939 control-port sequencer: after PLL lock + settle, writes NUM_REGS init-table entries over SPI, then hands the pins to the HPS.
// Latency: first CLATCH_N fall SETTLE_CYC+4 cycles after lock is seen; each frame is 2+50*CLK_DIV cycles.
// Backpressure: waits in WAIT_BUS while the HPS holds SS0 low; pin ownership only changes between frames.
module ad1939_cfg_arbiter #(
    parameter int         CLK_DIV    = 8,
    parameter int         NUM_REGS   = 17,
    parameter int         SETTLE_CYC = 4096,
    parameter logic [6:0] CHIP_ADDR  = 7'h04
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       pll_locked,
    input  logic       start,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       hps_sclk,
    input  logic       hps_mosi,
    input  logic       hps_ss0_n,
    output logic       hps_miso,
    output logic       codec_cclk,
    output logic       codec_cdata,
    output logic       codec_clatch_n,
    input  logic       codec_cout,
    output logic       busy,
    output logic       done,
    output logic       hps_owner
);

    localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [4:0]  IDX_LAST    = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK, S_SETTLE, S_WAIT_BUS, S_FETCH, S_LOAD, S_SHIFT, S_GAP, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nxt;
    logic [15:0] r_settle;
    logic [7:0]  r_div;
    logic        r_phase;      // SHIFT: 0 = CCLK low half, 1 = high half; GAP: 0 = latch hold, 1 = latch high
    logic [4:0]  r_bit;        // bits still to send after the current one
    logic [22:0] r_sr;         // remaining frame bits, MSB next
    logic [4:0]  r_idx;
    logic        r_cclk;
    logic        r_cdata;
    logic        r_clatch_n;
    logic        r_busy;
    logic        r_done;
    logic        r_owner;

    logic        w_div_end;
    logic        w_lock_lost;
    logic        w_bus_free;
    logic [23:0] w_frame_word;

    assign w_div_end    = (r_div == DIV_LAST);
    assign w_lock_lost  = (r_state != S_WAIT_LOCK) && !pll_locked;
    assign w_bus_free   = !(r_owner && !hps_ss0_n);
    assign w_frame_word = {CHIP_ADDR, 1'b0, 3'b000, r_idx, rom_data};

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= S_WAIT_LOCK;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next-state logic; losing lock overrides everything, including a coincident start.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_WAIT_LOCK: if (pll_locked) w_nxt = S_SETTLE;
            S_SETTLE:    if (r_settle == SETTLE_LAST) w_nxt = S_WAIT_BUS;
            S_WAIT_BUS:  if (w_bus_free) w_nxt = S_FETCH;
            S_FETCH:     w_nxt = S_LOAD;
            S_LOAD:      w_nxt = S_SHIFT;
            S_SHIFT:     if (w_div_end && r_phase && (r_bit == 5'd0)) w_nxt = S_GAP;
            S_GAP: begin
                if (w_div_end && r_phase) begin
                    w_nxt = (r_idx == IDX_LAST) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:      if (start) w_nxt = S_WAIT_BUS;
            default:     w_nxt = S_WAIT_LOCK;
        endcase
        if (w_lock_lost) begin
            w_nxt = S_WAIT_LOCK;
        end
    end

    // Codec pin mux: HPS signals pass straight through while it owns the bus.
    always_comb begin
        if (r_owner) begin
            codec_cclk     = hps_sclk;
            codec_cdata    = hps_mosi;
            codec_clatch_n = hps_ss0_n;
            hps_miso       = codec_cout;
        end else begin
            codec_cclk     = r_cclk;
            codec_cdata    = r_cdata;
            codec_clatch_n = r_clatch_n;
            hps_miso       = 1'b0;
        end
    end

    assign rom_addr  = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hps_owner = r_owner;

    // Sequencer datapath: settle counter, frame shifter, CCLK/latch timing and bus ownership.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_settle   <= '0;
            r_div      <= '0;
            r_phase    <= 1'b0;
            r_bit      <= '0;
            r_sr       <= '0;
            r_idx      <= '0;
            r_cclk     <= 1'b0;
            r_cdata    <= 1'b0;
            r_clatch_n <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_owner    <= 1'b0;
        end else begin
            r_busy <= (w_nxt != S_WAIT_LOCK) && (w_nxt != S_DONE);
            r_done <= (w_nxt == S_DONE);
            if (w_lock_lost) begin
                // Abandon any frame; ownership is left for WAIT_BUS to sort out.
                r_clatch_n <= 1'b1;
                r_cclk     <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT_LOCK: r_settle <= '0;
                    S_SETTLE:    r_settle <= r_settle + 16'd1;
                    S_WAIT_BUS: begin
                        if (w_bus_free) begin
                            r_owner <= 1'b0;
                            r_idx   <= '0;
                        end
                    end
                    S_LOAD: begin
                        r_sr       <= w_frame_word[22:0];
                        r_cdata    <= w_frame_word[23];
                        r_clatch_n <= 1'b0;
                        r_cclk     <= 1'b0;
                        r_div      <= '0;
                        r_phase    <= 1'b0;
                        r_bit      <= 5'd23;
                    end
                    S_SHIFT: begin
                        if (w_div_end) begin
                            r_div <= '0;
                            if (!r_phase) begin
                                r_phase <= 1'b1;
                                r_cclk  <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                r_cclk  <= 1'b0;
                                if (r_bit != 5'd0) begin
                                    r_bit   <= r_bit - 5'd1;
                                    r_cdata <= r_sr[22];
                                    r_sr    <= {r_sr[21:0], 1'b0};
                                end
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (w_div_end) begin
                            r_div <= '0;
                            if (!r_phase) begin
                                r_phase    <= 1'b1;
                                r_clatch_n <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                r_idx   <= r_idx + 5'd1;
                                if (r_idx == IDX_LAST) begin
                                    r_owner <= 1'b1;
                                end
                            end
                        end else begin
                            r_div <= r_div + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad1939_cfg_arbiter.sv
`timescale 1ns/1ps
// Bench for ad1939_cfg_arbiter: decodes codec SPI frames and scores them against a queue of expected frames.
// Latency: checks lock-to-latch, start-to-latch and HPS release-to-latch cycle counts.
// Backpressure: exercises HPS holding SS0 low across a start request.
module tb_ad1939_cfg_arbiter;

    localparam int CLK_DIV    = 2;
    localparam int NUM_REGS   = 17;
    localparam int SETTLE_CYC = 4;
    localparam int FRAME_CYC  = 2 + 50 * CLK_DIV;   // 102
    localparam int LOCK_LAT   = SETTLE_CYC + 4;     // 8

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       start = 1'b0;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic       hps_sclk = 1'b0;
    logic       hps_mosi = 1'b0;
    logic       hps_ss0_n = 1'b1;
    logic       hps_miso;
    logic       codec_cclk;
    logic       codec_cdata;
    logic       codec_clatch_n;
    logic       codec_cout = 1'b0;
    logic       busy;
    logic       done;
    logic       hps_owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Init table: data = 0x10 + address, one cycle after the address.
    always_ff @(posedge clk) rom_data <= 8'h10 + {3'b000, rom_addr};

    ad1939_cfg_arbiter #(
        .CLK_DIV    (CLK_DIV),
        .NUM_REGS   (NUM_REGS),
        .SETTLE_CYC (SETTLE_CYC),
        .CHIP_ADDR  (7'h04)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .pll_locked     (pll_locked),
        .start          (start),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .hps_sclk       (hps_sclk),
        .hps_mosi       (hps_mosi),
        .hps_ss0_n      (hps_ss0_n),
        .hps_miso       (hps_miso),
        .codec_cclk     (codec_cclk),
        .codec_cdata    (codec_cdata),
        .codec_clatch_n (codec_clatch_n),
        .codec_cout     (codec_cout),
        .busy           (busy),
        .done           (done),
        .hps_owner      (hps_owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [23:0] word;
        int          nbits;
    } frame_t;

    frame_t sb_q[$];

    task automatic push_frame(input int idx, input int nbits);
        frame_t      f;
        logic [23:0] w;
        w       = {8'h08, 3'b000, 5'(idx), 8'h10 + 8'(idx)};
        f.word  = w >> (24 - nbits);
        f.nbits = nbits;
        sb_q.push_back(f);
    endtask

    task automatic push_run();
        for (int i = 0; i < NUM_REGS; i++) push_frame(i, 24);
    endtask

    // ---------------- monitor ----------------
    int          mon_started = 0;
    int          mon_nbits = 0;
    int          mon_run = 0;
    int          mon_cyc = 0;
    int          mon_idle_edges = 0;
    int          last_fall = 0;
    bit          mon_in = 0;
    bit          last_full = 0;
    logic [4:0]  last_idx = '0;
    logic        prev_clatch = 1'b1;
    logic        prev_cclk = 1'b0;
    logic [23:0] mon_word = '0;
    frame_t      mon_f;

    always @(negedge clk) begin
        mon_cyc++;
        if (!rst_n || hps_owner) begin
            mon_in      = 0;
            last_full   = 0;
            prev_clatch = 1'b1;
            prev_cclk   = 1'b0;
        end else begin
            if (!mon_in) begin
                if (prev_clatch && !codec_clatch_n) begin
                    if (last_full && last_idx != 5'(NUM_REGS - 1))
                        chk("frame_period", mon_cyc - last_fall, FRAME_CYC);
                    chk("cclk_low_at_latch", codec_cclk, 0);
                    last_fall = mon_cyc;
                    mon_in    = 1;
                    mon_nbits = 0;
                    mon_word  = '0;
                    mon_run   = 1;
                    mon_started++;
                end else if (codec_cclk != prev_cclk) begin
                    mon_idle_edges++;
                end
            end else if (codec_clatch_n) begin
                if (mon_nbits == 24) chk("clatch_hold", mon_run, CLK_DIV);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %0d bits 0x%0h, want no frame at %0t",
                             mon_nbits, mon_word, $time);
                end else begin
                    mon_f = sb_q.pop_front();
                    chk("frame_bits", mon_nbits, mon_f.nbits);
                    chk("frame_word", mon_word, mon_f.word);
                end
                last_full = (mon_nbits == 24);
                last_idx  = mon_word[12:8];
                mon_in    = 0;
            end else if (codec_cclk != prev_cclk) begin
                if (codec_cclk) chk("cclk_low_phase", mon_run, CLK_DIV);
                else            chk("cclk_high_phase", mon_run, CLK_DIV);
                mon_run = 1;
                if (codec_cclk) begin
                    mon_word = {mon_word[22:0], codec_cdata};
                    mon_nbits++;
                end
            end else begin
                mon_run++;
            end
            prev_clatch = codec_clatch_n;
            prev_cclk   = codec_cclk;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) chk("busy_with_done", busy, 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (codec_clatch_n && n < 200);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 4000) begin
            tick();
            n++;
        end
        chk(name, done, 1);
    endtask

    task automatic wait_started(input int target, input string name);
        int n;
        n = 0;
        while (mon_started < target && n < 4000) begin
            tick();
            n++;
        end
        chk(name, mon_started >= target, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cclk"}, codec_cclk, 0);
        chk({tag, "_cdata"}, codec_cdata, 0);
        chk({tag, "_clatch_n"}, codec_clatch_n, 1);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_owner"}, hps_owner, 0);
        chk({tag, "_miso"}, hps_miso, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int n_own;
        int base;

        #1 rst_n = 1'b0;
        codec_cout = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (10) tick();
        chk("prelock_busy", busy, 0);

        // Run A: first configuration, a stray start mid-frame must be ignored.
        push_run();
        base = mon_started;
        pll_locked = 1'b1;
        wait_latch(n);
        chk("lock_to_latch", n, LOCK_LAT);
        chk("run_a_busy", busy, 1);
        wait_started(base + 3, "run_a_reach_frame3");
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("run_a_done");
        chk("run_a_owner", hps_owner, 1);
        chk("run_a_idle", busy, 0);
        repeat (30) tick();
        chk("run_a_frames", mon_started - base, NUM_REGS);
        chk("run_a_queue", sb_q.size(), 0);

        // Run B: HPS mid-transfer when start arrives; sequencer waits for SS0 release.
        hps_ss0_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hps_sclk   = i[0];
            hps_mosi   = i[1];
            codec_cout = !i[0];
            #1;
            chk("hps_cclk", codec_cclk, i[0]);
            chk("hps_cdata", codec_cdata, i[1]);
            chk("hps_clatch", codec_clatch_n, 0);
            chk("hps_miso", hps_miso, !i[0]);
            tick();
        end
        base = mon_started;
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_b_done_clear", done, 0);
        chk("run_b_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            hps_sclk = !i[0];
            #1;
            chk("run_b_follow", codec_cclk, !i[0]);
            chk("run_b_owner", hps_owner, 1);
            tick();
        end
        hps_sclk   = 1'b0;
        codec_cout = 1'b0;
        hps_ss0_n  = 1'b1;
        n = 0;
        n_own = 0;
        do begin
            tick();
            n++;
            if (!hps_owner && n_own == 0) n_own = n;
        end while (codec_clatch_n && n < 50);
        chk("release_to_owner", n_own, 1);
        chk("release_to_latch", n, 3);
        wait_done("run_b_done");
        chk("run_b_frames", mon_started - base, NUM_REGS);
        chk("run_b_queue", sb_q.size(), 0);

        // Run C: rerun via start (no settle), lose lock at bit 12 of frame 5.
        base = mon_started;
        for (int i = 0; i < 4; i++) push_frame(i, 24);
        push_frame(4, 12);
        start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            start = 1'b0;
        end while (codec_clatch_n && n < 50);
        chk("start_to_latch", n, 4);
        n = 0;
        while (!(mon_started == base + 5 && mon_nbits == 12) && n < 4000) begin
            tick();
            n++;
        end
        chk("reach_bit12_frame5", mon_nbits, 12);
        pll_locked = 1'b0;
        tick();
        chk("unlock_clatch_n", codec_clatch_n, 1);
        chk("unlock_cclk", codec_cclk, 0);
        chk("unlock_done", done, 0);
        chk("unlock_busy", busy, 0);
        chk("unlock_owner", hps_owner, 0);
        repeat (20) tick();
        chk("unlocked_busy", busy, 0);
        chk("unlock_queue", sb_q.size(), 0);
        base = mon_started;
        push_run();
        pll_locked = 1'b1;
        wait_latch(n);
        chk("relock_to_latch", n, LOCK_LAT);
        wait_done("run_c_done");
        chk("run_c_frames", mon_started - base, NUM_REGS);
        chk("run_c_queue", sb_q.size(), 0);

        // Run D: asynchronous reset in the middle of a frame.
        base = mon_started;
        push_run();
        codec_cout = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_started(base + 3, "run_d_reach_frame3");
        repeat (7) tick();
        #1 rst_n = 1'b0;
        #1;
        sb_q.delete();
        chk_reset_outputs("async_reset");
        repeat (5) tick();
        chk("reset_hold_cclk", codec_cclk, 0);
        rst_n = 1'b1;
        base = mon_started;
        push_run();
        wait_latch(n);
        chk("post_reset_to_latch", n, LOCK_LAT);
        wait_done("run_d_done");
        chk("run_d_frames", mon_started - base, NUM_REGS);
        chk("run_d_queue", sb_q.size(), 0);
        chk("cclk_edges_outside_frames", mon_idle_edges, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ad1939_cfg_arbiter.md
# ad1939_cfg_arbiter

Hardware configuration sequencer and SPI arbiter for the AD1939 codec control port. After reset, and each time the MCLK PLL regains lock, it waits a settle interval. It then writes every AD1939 control register from an external init table over the codec SPI pins. Once configuration is complete, it hands the SPI pins to the HPS SPI master (spim0 SS0), switching owners only between frames. It sits between the HPS SPI conduit and the codec control pins in the system top level.

## Interface
- CLK_DIV, 8: clk cycles per CCLK half-period; legal range 2..255.
- NUM_REGS, 17: number of registers written, at addresses 0..NUM_REGS-1; legal range 1..32.
- SETTLE_CYC, 4096: clk cycles to wait after pll_locked rises before the first frame; legal range 1..65535.
- CHIP_ADDR, 7'h04: AD1939 global address; the first frame byte is {CHIP_ADDR, 1'b0} = 8'h08.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  MCLK PLL lock, already synchronous to clk_clk.
- start  in  1  one-cycle pulse that requests reconfiguration.
- rom_addr  out  5  init-table address.
- rom_data  in  8  init-table data; valid one cycle after rom_addr changes.
- hps_sclk, hps_mosi, hps_ss0_n  in  1 each  HPS SPI master signals.
- hps_miso  out  1  codec_cout when the HPS owns the bus, else 0.
- codec_cclk, codec_cdata, codec_clatch_n  out  1 each  codec control pins.
- codec_cout  in  1  codec readback data.
- busy  out  1  sequencer is running (any state other than IDLE/DONE).
- done  out  1  configuration completed since the last lock or start.
- hps_owner  out  1  1 = HPS signals are muxed onto the codec pins.

## Operation
- FSM states: WAIT_LOCK, SETTLE, WAIT_BUS, FETCH, LOAD, SHIFT, GAP, DONE.
- Reset: state goes to WAIT_LOCK. Output values in reset: codec_cclk=0, codec_cdata=0, codec_clatch_n=1, rom_addr=0, busy=0, done=0, hps_owner=0, hps_miso=0.
- WAIT_LOCK: when pll_locked=1, clear the settle counter and go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to WAIT_BUS.
- WAIT_BUS:
  - If hps_owner=1 and hps_ss0_n=0, wait.
  - Otherwise set hps_owner=0, set reg index to 0, and go to FETCH.
- FETCH: drive rom_addr=index (1 cycle).
- LOAD: capture shift register = {CHIP_ADDR, 1'b0, 3'b000, index[4:0], rom_data}, 24 bits. Set codec_clatch_n=0 and codec_cclk=0. Drive codec_cdata=bit 23 (1 cycle).
- SHIFT:
  - Each bit: CLK_DIV cycles with CCLK=0, then CLK_DIV cycles with CCLK=1. The codec samples on the rising edge.
  - The next bit is driven on the cycle CCLK falls.
  - After bit 0's high phase, drive CCLK=0 and go to GAP.
- GAP:
  - Hold codec_clatch_n=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - Then index+1. If index==NUM_REGS-1, go to DONE; else go to FETCH.
- DONE: done=1, busy=0. Set hps_owner=1 on the first cycle in DONE.
- Codec pin mux:
  - hps_owner=1: codec_cclk=hps_sclk, codec_cdata=hps_mosi, codec_clatch_n=hps_ss0_n (combinational).
  - hps_owner=0: the sequencer drives the codec pins.
- start:
  - Honoured only in DONE: clear done and go to WAIT_BUS (skip SETTLE).
  - Ignored in every other state.
- pll_locked falling in any state other than WAIT_LOCK:
  - Next cycle: codec_clatch_n=1 (sequencer-driven), codec_cclk=0, done=0, busy=0.
  - Go to WAIT_LOCK; the frame in progress is abandoned.
  - hps_owner holds its current value until WAIT_BUS clears it.
- Simultaneous start and pll_locked fall: the lock loss wins.

## Timing
- Frame length: 2 + 48·CLK_DIV + 2·CLK_DIV cycles (402 at CLK_DIV=8). Full configuration at defaults: 17·402 = 6834 cycles after SETTLE ends.
- First CCLK rising edge occurs CLK_DIV cycles after codec_clatch_n falls. codec_clatch_n rises CLK_DIV cycles after the last CCLK falling edge.
- Latency from pll_locked rising to codec_clatch_n first falling: 1 + SETTLE_CYC + 1 (WAIT_BUS) + 2 cycles, with no HPS contention.
- hps_owner changes only when hps_ss0_n=1 or the sequencer is idle; no glitch is allowed mid-frame.
- busy and done are registered outputs, updated one cycle after the state transition.

## Test plan
- Default reset release; ROM returns data = 8'h10+addr; pll_locked=1 from cycle 10 -> 17 frames decoded as 08_00_10 through 08_10_20; done=1 and hps_owner=1 after the last GAP; busy is never high together with done.
- CLK_DIV=2, SETTLE_CYC=4 -> CCLK high and low phases are exactly 2 cycles each; clatch_n setup and hold are 2 cycles each; 24 rising edges per frame; frame length is 102 cycles.
- pll_locked dropped at bit 12 of frame 5 -> codec_clatch_n=1 the next cycle and done=0; on relock, SETTLE repeats and the sequence restarts at rom_addr=0.
- In DONE, HPS holds hps_ss0_n=0 and toggles hps_sclk; start is pulsed -> codec pins keep following the HPS until hps_ss0_n rises; then hps_owner=0 and the frame for reg 0 begins 3 cycles later.
- start pulsed during SHIFT -> ignored, and exactly NUM_REGS frames are sent. start pulsed in DONE -> full rerun with no SETTLE interval.
- Reset asserted mid-frame -> all outputs take their reset values asynchronously, with no further CCLK edges until pll_locked and SETTLE complete again.
